apb_slv_frontend: RTL and testbench

- APB3/APB4 responder front-end for bus1 peripherals; the completer side of the APB link driven by the AXI-to-APB bridge.
- Decodes one APB transfer into a simple request/response handshake toward a peripheral register bank.
- Inserts wait states, enforces a response timeout, and publishes the device config descriptor.
- One instance per APB slave, placed between the bus1 vector slot and the peripheral core.

---
 rtl/apb_slv_frontend_pkg.sv | 28 ++
 rtl/types_amba_pkg.sv | 38 +++
 rtl/apb_slv_frontend.sv | 120 ++++++++++++
 tb/tb_apb_slv_frontend.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_slv_frontend_pkg.sv
// State encoding and register bundle for the APB responder front-end.
package apb_slv_frontend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_REQUEST   = 2'd1,
        ST_WAIT_RESP = 2'd2,
        ST_RESPONSE  = 2'd3
    } state_type;

    typedef struct packed {
        state_type   state;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
        logic        pready;
        logic        dropped;
        logic [15:0] cnt;
    } registers;

    localparam registers R_RESET = '{
        ST_IDLE, 32'd0, 1'b0, 32'd0, 4'd0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0
    };

endpackage

// File: rtl/types_amba_pkg.sv
// Shared AMBA/APB bus types and plug-and-play descriptor definitions for bus1 slaves.
package types_amba_pkg;

    localparam logic [15:0] VENDOR_OPTIMITECH       = 16'h00F1;
    localparam logic [1:0]  PNP_CFG_TYPE_SLAVE      = 2'd2;
    localparam logic [7:0]  PNP_CFG_DEV_DESCR_BYTES = 8'h10;

    typedef struct packed {
        logic [31:0] addr_start;
        logic [31:0] addr_end;
    } mapinfo_type;

    typedef struct packed {
        logic [7:0]  descrsize;
        logic [1:0]  descrtype;
        logic [31:0] addr_start;
        logic [31:0] addr_end;
        logic [15:0] vid;
        logic [15:0] did;
    } dev_config_type;

    typedef struct packed {
        logic [31:0] paddr;
        logic        pwrite;
        logic [31:0] pwdata;
        logic [3:0]  pstrb;
        logic        pselx;
        logic        penable;
        logic [2:0]  pprot;
    } apb_in_type;

    typedef struct packed {
        logic        pready;
        logic        pslverr;
        logic [31:0] prdata;
    } apb_out_type;

endpackage

// File: rtl/apb_slv_frontend.sv
// APB completer front-end: turns one APB transfer into a request/response
// handshake toward a peripheral register bank, with wait states and timeout.
module apb_slv_frontend
    import types_amba_pkg::*;
    import apb_slv_frontend_pkg::*;
#(
    parameter logic [15:0] vid     = VENDOR_OPTIMITECH,
    parameter logic [15:0] did     = 16'h0000,
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic           i_clk,
    input  logic           i_nrst,
    input  mapinfo_type    i_mapinfo,
    output dev_config_type o_cfg,
    input  apb_in_type     i_apbi,
    output apb_out_type    o_apbo,
    output logic           o_req_valid,
    output logic [31:0]    o_req_addr,
    output logic           o_req_write,
    output logic [31:0]    o_req_wdata,
    output logic [3:0]     o_req_wstrb,
    input  logic           i_req_ready,
    input  logic           i_resp_valid,
    input  logic [31:0]    i_resp_rdata,
    input  logic           i_resp_err
);

    registers    r;
    logic        setup;
    logic        busy;
    logic        resp_now;
    logic        timeout_hit;
    logic        abort;
    logic        done;
    logic        gone;
    logic        done_err;
    logic [31:0] offset;
    logic [31:0] done_rdata;
    logic        unused_pprot;

    assign unused_pprot = ^i_apbi.pprot;

    assign offset      = i_apbi.paddr - i_mapinfo.addr_start;
    assign setup       = i_apbi.pselx & ~i_apbi.penable;
    assign busy        = (r.state == ST_REQUEST) || (r.state == ST_WAIT_RESP);
    assign resp_now    = i_resp_valid &&
                         (((r.state == ST_REQUEST) && i_req_ready) || (r.state == ST_WAIT_RESP));
    assign timeout_hit = (TIMEOUT != 16'd0) && (r.cnt == TIMEOUT - 16'd1);
    assign abort       = (r.state == ST_REQUEST) && !i_req_ready && !i_apbi.pselx;
    assign done        = busy && !abort && (resp_now || timeout_hit);
    // Once the master has walked away, the completion is swallowed silently.
    assign gone        = r.dropped || !i_apbi.pselx;
    assign done_rdata  = !resp_now ? 32'hFFFF_FFFF : (r.write ? 32'd0 : i_resp_rdata);
    assign done_err    = !resp_now || i_resp_err;

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r <= R_RESET;
        end else begin
            case (r.state)
                ST_IDLE: begin
                    if (setup) begin
                        r.state   <= ST_REQUEST;
                        r.addr    <= {offset[31:2], 2'b00};
                        r.write   <= i_apbi.pwrite;
                        r.wdata   <= i_apbi.pwdata;
                        r.wstrb   <= i_apbi.pwrite ? i_apbi.pstrb : 4'd0;
                        r.cnt     <= 16'd0;
                        r.dropped <= 1'b0;
                    end
                end
                ST_REQUEST, ST_WAIT_RESP: begin
                    r.cnt <= r.cnt + 16'd1;
                    if (abort) begin
                        r.state <= ST_IDLE;
                    end else if (done) begin
                        if (gone) begin
                            r.state <= ST_IDLE;
                        end else begin
                            r.state  <= ST_RESPONSE;
                            r.pready <= 1'b1;
                            r.rdata  <= done_rdata;
                            r.err    <= done_err;
                        end
                    end else if ((r.state == ST_REQUEST) && i_req_ready) begin
                        r.state   <= ST_WAIT_RESP;
                        r.dropped <= !i_apbi.pselx;
                    end else if (!i_apbi.pselx) begin
                        r.dropped <= 1'b1;
                    end
                end
                ST_RESPONSE: begin
                    r.state  <= ST_IDLE;
                    r.pready <= 1'b0;
                    r.rdata  <= 32'd0;
                    r.err    <= 1'b0;
                end
                default: r.state <= ST_IDLE;
            endcase
        end
    end

    assign o_req_valid = (r.state == ST_REQUEST);
    assign o_req_addr  = r.addr;
    assign o_req_write = r.write;
    assign o_req_wdata = r.wdata;
    assign o_req_wstrb = r.wstrb;

    assign o_apbo.pready  = r.pready;
    assign o_apbo.pslverr = r.err;
    assign o_apbo.prdata  = r.rdata;

    assign o_cfg.descrsize  = PNP_CFG_DEV_DESCR_BYTES;
    assign o_cfg.descrtype  = PNP_CFG_TYPE_SLAVE;
    assign o_cfg.addr_start = i_mapinfo.addr_start;
    assign o_cfg.addr_end   = i_mapinfo.addr_end;
    assign o_cfg.vid        = vid;
    assign o_cfg.did        = did;

endmodule

// File: tb/tb_apb_slv_frontend.sv
// Bench for apb_slv_frontend: vector table, randomized transfers against a rule model, corner sequences.
module tb_apb_slv_frontend;
    import types_amba_pkg::*;

    localparam logic [31:0] BASE = 32'h1001_0000;
    localparam int          TMO  = 16;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    mapinfo_type    mapinfo;
    dev_config_type cfg;
    apb_in_type     apbi;
    apb_out_type    apbo;
    logic           req_valid;
    logic [31:0]    req_addr;
    logic           req_write;
    logic [31:0]    req_wdata;
    logic [3:0]     req_wstrb;
    logic           req_ready;
    logic           resp_valid;
    logic [31:0]    resp_rdata;
    logic           resp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_slv_frontend #(
        .vid(16'h00F1),
        .did(16'h0071),
        .TIMEOUT(16'd16)
    ) dut (
        .i_clk(clk),
        .i_nrst(nrst),
        .i_mapinfo(mapinfo),
        .o_cfg(cfg),
        .i_apbi(apbi),
        .o_apbo(apbo),
        .o_req_valid(req_valid),
        .o_req_addr(req_addr),
        .o_req_write(req_write),
        .o_req_wdata(req_wdata),
        .o_req_wstrb(req_wstrb),
        .i_req_ready(req_ready),
        .i_resp_valid(resp_valid),
        .i_resp_rdata(resp_rdata),
        .i_resp_err(resp_err)
    );

    typedef struct {
        logic        write;
        logic [31:0] paddr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          rk;
        int          sk;
        logic [31:0] rdata;
        logic        err;
        logic [31:0] exp_addr;
        logic [31:0] exp_prdata;
        logic [3:0]  exp_wstrb;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Rule model: request issued at k=0, response at k=sk, timeout fires at k=TMO-1.
    function automatic vec_t model(input vec_t v);
        vec_t m = v;
        m.exp_addr  = (v.paddr - BASE) & 32'hFFFF_FFFC;
        m.exp_wstrb = v.write ? v.strb : 4'd0;
        if (v.sk <= TMO - 1) begin
            m.exp_lat    = v.sk + 1;
            m.exp_prdata = v.write ? 32'd0 : v.rdata;
            m.exp_err    = v.err;
        end else begin
            m.exp_lat    = TMO;
            m.exp_prdata = 32'hFFFF_FFFF;
            m.exp_err    = 1'b1;
        end
        return m;
    endfunction

    task automatic run(input vec_t v, input string tag);
        int   k;
        logic stable;
        logic seen;
        apbi.paddr   = v.paddr;
        apbi.pwrite  = v.write;
        apbi.pwdata  = v.wdata;
        apbi.pstrb   = v.strb;
        apbi.pselx   = 1'b1;
        apbi.penable = 1'b0;
        cyc();
        apbi.penable = 1'b1;
        chk({tag, " req_addr"}, req_addr, v.exp_addr);
        chk({tag, " req_wstrb"}, {28'd0, req_wstrb}, {28'd0, v.exp_wstrb});
        chk({tag, " req_write"}, {31'd0, req_write}, {31'd0, v.write});
        chk({tag, " req_wdata"}, req_wdata, v.wdata);
        stable = 1'b1;
        seen   = 1'b0;
        k      = 0;
        while (k < 40) begin
            if (apbo.pready) begin
                seen = 1'b1;
                break;
            end
            if (k <= v.rk && k < TMO) begin
                if (!req_valid || req_addr !== v.exp_addr || req_wdata !== v.wdata ||
                    req_wstrb !== v.exp_wstrb)
                    stable = 1'b0;
            end else if (req_valid) begin
                stable = 1'b0;
            end
            req_ready  = (k == v.rk);
            resp_valid = (k == v.sk);
            resp_rdata = (k == v.sk) ? v.rdata : $urandom();
            resp_err   = (k == v.sk) ? v.err : 1'($urandom_range(0, 1));
            cyc();
            k++;
        end
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        chk({tag, " pready_seen"}, {31'd0, seen}, 32'd1);
        chk({tag, " latency"}, k, v.exp_lat);
        chk({tag, " prdata"}, apbo.prdata, v.exp_prdata);
        chk({tag, " pslverr"}, {31'd0, apbo.pslverr}, {31'd0, v.exp_err});
        chk({tag, " req_stable"}, {31'd0, stable}, 32'd1);
        cyc();
        chk({tag, " pready_single"}, {31'd0, apbo.pready}, 32'd0);
        apbi.pselx   = 1'b0;
        apbi.penable = 1'b0;
    endtask

    task automatic no_pready(input string name, input int n);
        logic hit = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (apbo.pready || req_valid) hit = 1'b1;
            cyc();
        end
        chk(name, {31'd0, hit}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t v;
        mapinfo.addr_start = BASE;
        mapinfo.addr_end   = BASE + 32'h0000_FFFF;
        apbi       = '0;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;

        //               wr    paddr          wdata          strb  rk  sk  rdata          err   exp_addr       exp_prdata     wstrb  eerr  lat
        tbl[0] = '{1'b0, 32'h1001_0008, 32'h0000_0000, 4'hF, 0,  0,  32'hCAFE_BABE, 1'b0, 32'h0000_0008, 32'hCAFE_BABE, 4'h0, 1'b0, 1};
        tbl[1] = '{1'b1, 32'h1001_0013, 32'h1234_5678, 4'h3, 3,  5,  32'h7777_7777, 1'b0, 32'h0000_0010, 32'h0000_0000, 4'h3, 1'b0, 6};
        tbl[2] = '{1'b0, 32'h1001_0020, 32'h0000_0000, 4'h0, 1,  2,  32'hDEAD_BEEF, 1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 4'h0, 1'b1, 3};
        tbl[3] = '{1'b0, 32'h1001_0024, 32'h0000_0000, 4'h0, 0,  1,  32'h0BAD_F00D, 1'b0, 32'h0000_0024, 32'h0BAD_F00D, 4'h0, 1'b0, 2};
        tbl[4] = '{1'b0, 32'h1001_0004, 32'h0000_0000, 4'h0, 2,  99, 32'h0000_0000, 1'b0, 32'h0000_0004, 32'hFFFF_FFFF, 4'h0, 1'b1, 16};
        tbl[5] = '{1'b0, 32'h1001_0030, 32'h0000_0000, 4'h0, 0,  15, 32'h55AA_55AA, 1'b0, 32'h0000_0030, 32'h55AA_55AA, 4'h0, 1'b0, 16};
        tbl[6] = '{1'b1, 32'h1000_0004, 32'hA5A5_A5A5, 4'hF, 20, 20, 32'h0000_0000, 1'b0, 32'hFFFF_0004, 32'hFFFF_FFFF, 4'hF, 1'b1, 16};
        tbl[7] = '{1'b1, 32'h1001_0100, 32'h0F0F_0F0F, 4'hC, 0,  0,  32'h1111_1111, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'hC, 1'b0, 1};

        // Reset state and descriptor
        cyc();
        chk("rst req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst pready", {31'd0, apbo.pready}, 32'd0);
        chk("rst pslverr", {31'd0, apbo.pslverr}, 32'd0);
        chk("rst prdata", apbo.prdata, 32'd0);
        chk("rst req_addr", req_addr, 32'd0);
        chk("cfg descrtype", {30'd0, cfg.descrtype}, 32'd2);
        chk("cfg addr_start", cfg.addr_start, BASE);
        chk("cfg addr_end", cfg.addr_end, 32'h1001_FFFF);
        chk("cfg ids", {cfg.vid, cfg.did}, 32'h00F1_0071);
        cyc();
        nrst = 1'b1;
        cyc();

        for (int i = 0; i < 8; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Randomized back-to-back transfers
        for (int i = 0; i < 40; i++) begin
            v.write = 1'($urandom_range(0, 1));
            v.paddr = BASE + $urandom_range(0, 32'h3FF);
            v.wdata = $urandom();
            v.strb  = 4'($urandom_range(0, 15));
            v.rk    = $urandom_range(0, 5);
            v.sk    = v.rk + (($urandom_range(0, 9) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 5));
            v.rdata = $urandom();
            v.err   = ($urandom_range(0, 3) == 0);
            v = model(v);
            run(v, $sformatf("rnd%0d", i));
        end

        // Access phase without setup is ignored
        apbi.pselx   = 1'b1;
        apbi.penable = 1'b1;
        no_pready("proto_err ignored", 4);
        apbi.pselx   = 1'b0;
        apbi.penable = 1'b0;
        cyc();

        // Abort while request not yet accepted
        apbi.paddr  = BASE + 32'h44;
        apbi.pwrite = 1'b0;
        apbi.pselx  = 1'b1;
        cyc();
        chk("abort req_valid_before", {31'd0, req_valid}, 32'd1);
        apbi.pselx = 1'b0;
        cyc();
        chk("abort req_valid_after", {31'd0, req_valid}, 32'd0);
        no_pready("abort no_pready", 20);

        // Master leaves during WaitResp: completion is swallowed
        apbi.paddr = BASE + 32'h48;
        apbi.pselx = 1'b1;
        cyc();
        apbi.penable = 1'b1;
        req_ready    = 1'b1;
        cyc();
        req_ready    = 1'b0;
        apbi.pselx   = 1'b0;
        apbi.penable = 1'b0;
        cyc();
        cyc();
        resp_valid = 1'b1;
        resp_rdata = 32'h1357_9BDF;
        cyc();
        resp_valid = 1'b0;
        no_pready("dropped no_pready", 20);

        // Reset in WaitResp clears outputs immediately; late response ignored
        apbi.paddr  = BASE + 32'h40;
        apbi.pwrite = 1'b1;
        apbi.pwdata = 32'hFACE_0001;
        apbi.pstrb  = 4'hF;
        apbi.pselx  = 1'b1;
        cyc();
        apbi.penable = 1'b1;
        req_ready    = 1'b1;
        cyc();
        req_ready = 1'b0;
        chk("mid req_valid_waitresp", {31'd0, req_valid}, 32'd0);
        nrst = 1'b0;
        #1;
        chk("mid rst req_addr", req_addr, 32'd0);
        chk("mid rst req_wdata", req_wdata, 32'd0);
        chk("mid rst wstrb_write", {27'd0, req_write, req_wstrb}, 32'd0);
        #3;
        nrst         = 1'b1;
        apbi.pselx   = 1'b0;
        apbi.penable = 1'b0;
        cyc();
        resp_valid = 1'b1;
        cyc();
        resp_valid = 1'b0;
        no_pready("mid rst late_resp", 20);

        run(tbl[3], "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
